// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and block memory.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT/WB_COUNT statistics outputs.
module dcache_controller #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [7:0]        ADDRESS,
    input  logic [7:0]        WRITEDATA,
    output logic [7:0]        READDATA,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [5:0]        MEM_ADDRESS,
    output logic [31:0]       MEM_WRITEDATA,
    input  logic [31:0]       MEM_READDATA,
    input  logic              MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] HIT_COUNT,
    output logic [STAT_W-1:0] MISS_COUNT,
    output logic [STAT_W-1:0] WB_COUNT
`endif
);

    localparam int unsigned TAG_W = 8 - 2 - INDEX_W;
    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {StIdle, StWriteBack, StMemRead, StUpdate} state_e;

    state_e             state_q, state_d;
    logic [31:0]        data_q [LINES];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q, dirty_q;
    logic [7:0]         readdata_q;
    logic [31:0]        fill_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] idx;
    logic [4:0]         bsel;
    logic [31:0]        line;
    logic [7:0]         rd_byte;
    logic               hit, hit_rd, hit_wr, upd_we, fill_cap;

    assign req_tag = ADDRESS[7 -: TAG_W];
    assign idx     = ADDRESS[2 +: INDEX_W];
    assign bsel    = {ADDRESS[1:0], 3'b000};
    assign line    = data_q[idx];
    assign rd_byte = line[bsel +: 8];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

    always_comb begin
        state_d       = state_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = {req_tag, idx};
        MEM_WRITEDATA = line;
        READDATA      = readdata_q;
        hit_rd        = 1'b0;
        hit_wr        = 1'b0;
        upd_we        = 1'b0;
        fill_cap      = 1'b0;
        case (state_q)
            StIdle: begin
                if (READ || WRITE) begin
                    if (hit) begin
                        // WRITE wins when both strobes are high.
                        hit_wr = WRITE;
                        hit_rd = READ && !WRITE;
                        if (hit_rd) READDATA = rd_byte;
                    end else begin
                        BUSYWAIT = 1'b1;
                        state_d  = (valid_q[idx] && dirty_q[idx]) ? StWriteBack : StMemRead;
                    end
                end
            end
            StWriteBack: begin
                BUSYWAIT    = 1'b1;
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {tag_q[idx], idx};
                if (!MEM_BUSYWAIT) state_d = StMemRead;
            end
            StMemRead: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_d  = StUpdate;
                    fill_cap = 1'b1;
                end
            end
            StUpdate: begin
                BUSYWAIT = 1'b1;
                upd_we   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Reset aborts any transaction immediately and quiets every strobe.
        if (RESET) begin
            state_d   = StIdle;
            BUSYWAIT  = 1'b0;
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
            READDATA  = readdata_q;
            hit_rd    = 1'b0;
            hit_wr    = 1'b0;
            upd_we    = 1'b0;
            fill_cap  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            dirty_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (hit_rd) readdata_q <= rd_byte;
            if (hit_wr) dirty_q[idx] <= 1'b1;
            if (upd_we) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_cap) fill_q <= MEM_READDATA;
        if (hit_wr) data_q[idx][bsel +: 8] <= WRITEDATA;
        if (upd_we) begin
            data_q[idx] <= fill_q;
            tag_q[idx]  <= req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic              after_fill_q;

    // The hit that completes a miss is not counted as a hit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            wb_cnt_q     <= '0;
            after_fill_q <= 1'b0;
        end else begin
            after_fill_q <= (state_q == StUpdate);
            if ((hit_rd || hit_wr) && !after_fill_q && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (state_q == StIdle && state_d != StIdle && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
            if (state_q == StWriteBack && state_d == StMemRead && wb_cnt_q != '1) begin
                wb_cnt_q <= wb_cnt_q + 1'b1;
            end
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
    assign WB_COUNT   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized scoreboard bench for dcache_controller against a byte-level memory/cache reference model.
module tb_dcache_controller;

    logic        CLK = 1'b0;
    logic        RESET, READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT, MISS_COUNT, WB_COUNT;
`endif

    dcache_controller dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT),
        .WB_COUNT     (WB_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Block memory: busy for mem_lat cycles after a strobe rises, then completes on the next edge.
    logic [31:0] init_blk [64];
    logic [31:0] mem_blk  [64];
    logic        mem_load;
    int unsigned mem_lat;
    int unsigned mem_cnt;

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_lat);
    assign MEM_READDATA = mem_blk[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem_blk[i] <= init_blk[i];
            mem_cnt <= 0;
        end else if (!(MEM_READ || MEM_WRITE)) begin
            mem_cnt <= 0;
        end else if (MEM_BUSYWAIT) begin
            mem_cnt <= mem_cnt + 1;
        end else begin
            mem_cnt <= 0;
            if (MEM_WRITE) mem_blk[MEM_ADDRESS] <= MEM_WRITEDATA;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {int stall; bit is_rd; logic [7:0] data;} req_t;
    typedef struct {bit wr; logic [5:0] addr; logic [31:0] data;} mem_t;
    req_t req_q[$];
    mem_t mem_q[$];

    // Reference model: CPU-visible bytes, backing-store bytes, and which block each line holds.
    logic [7:0] ref_mem [256];
    logic [7:0] bk_mem  [256];
    bit         m_vld [8];
    bit         m_dty [8];
    logic [2:0] m_tag [8];

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = bk_mem[i];
        for (int i = 0; i < 8; i++) begin
            m_vld[i] = 1'b0;
            m_dty[i] = 1'b0;
        end
        req_q.delete();
        mem_q.delete();
    endtask

    // Monitor: sampled mid-cycle, pops expectations when the DUT completes something.
    int         stall_cnt = 0;
    logic [7:0] exp_last  = 8'h00;

    initial begin
        forever begin
            @(negedge CLK);
            if (RESET) begin
                stall_cnt = 0;
                exp_last  = 8'h00;
            end else begin
                if (MEM_READ && MEM_WRITE) check("strobes_exclusive", 32'd1, 32'd0);
                if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) begin
                    if (mem_q.size() == 0) begin
                        check("mem_unexpected", {MEM_WRITE, MEM_ADDRESS}, 32'd0);
                    end else begin
                        automatic mem_t e = mem_q.pop_front();
                        check("mem_is_write", {31'd0, MEM_WRITE}, {31'd0, e.wr});
                        check("mem_read_excl", {31'd0, MEM_READ}, {31'd0, !e.wr});
                        check("mem_addr", {26'd0, MEM_ADDRESS}, {26'd0, e.addr});
                        if (e.wr) check("wb_data", MEM_WRITEDATA, e.data);
                    end
                end
                if (READ || WRITE) begin
                    if (BUSYWAIT) begin
                        stall_cnt++;
                    end else if (req_q.size() == 0) begin
                        check("req_unexpected", 32'd1, 32'd0);
                    end else begin
                        automatic req_t r = req_q.pop_front();
                        check("stall_cycles", stall_cnt, r.stall);
                        if (r.is_rd) begin
                            check("readdata", {24'd0, READDATA}, {24'd0, r.data});
                            exp_last = r.data;
                        end
                        stall_cnt = 0;
                    end
                end else begin
                    check("idle_busywait", {31'd0, BUSYWAIT}, 32'd0);
                    check("idle_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
                    check("idle_readdata_hold", {24'd0, READDATA}, {24'd0, exp_last});
                end
            end
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd);
        automatic int         idx = int'(a[4:2]);
        automatic logic [2:0] tg  = a[7:5];
        automatic int         st  = 0;
        automatic int         n   = 0;
        if (!(m_vld[idx] && m_tag[idx] == tg)) begin
            st = 2 + int'(mem_lat) + 1;
            if (m_vld[idx] && m_dty[idx]) begin
                automatic logic [5:0] vb = {m_tag[idx], a[4:2]};
                automatic int b = int'(vb) * 4;
                st += int'(mem_lat) + 1;
                mem_q.push_back('{1'b1, vb, {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]}});
                for (int k = 0; k < 4; k++) bk_mem[b+k] = ref_mem[b+k];
            end
            mem_q.push_back('{1'b0, a[7:2], 32'h0});
            m_vld[idx] = 1'b1;
            m_tag[idx] = tg;
            m_dty[idx] = 1'b0;
        end
        if (wr) begin
            ref_mem[a] = wd;
            m_dty[idx] = 1'b1;
        end
        req_q.push_back('{st, rd && !wr, ref_mem[a]});
        @(posedge CLK);
        #1;
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = wd;
        do begin
            @(negedge CLK);
            n++;
        end while (BUSYWAIT && n < 200);
        if (BUSYWAIT) check("request_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        READ  = 1'b0;
        WRITE = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    initial begin
        RESET     = 1'b1;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 8'h00;
        WRITEDATA = 8'h00;
        mem_lat   = 2;
        mem_load  = 1'b1;
        for (int i = 0; i < 64; i++) init_blk[i] = $urandom;
        init_blk[1] = 32'h44332211;
        for (int i = 0; i < 256; i++) bk_mem[i] = init_blk[i/4][8*(i%4) +: 8];
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RESET    = 1'b0;
        mem_load = 1'b0;

        @(negedge CLK);
        check("rst_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("rst_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("rst_mem_write", {31'd0, MEM_WRITE}, 32'd0);
        check("rst_readdata", {24'd0, READDATA}, 32'd0);

        do_req(1'b1, 1'b0, 8'h05, 8'h00);   // clean miss, fill block 0x01
        do_req(1'b1, 1'b0, 8'h05, 8'h00);   // hit, no stall
        do_req(1'b0, 1'b1, 8'h06, 8'hAB);   // write hit, line 1 dirty
        do_req(1'b0, 1'b1, 8'h26, 8'h5C);   // dirty miss: write back 0x01, fill 0x09
`ifdef DCACHE_STATS_EN
        @(negedge CLK);
        check("hit_count", {16'd0, HIT_COUNT}, 32'd2);
        check("miss_count", {16'd0, MISS_COUNT}, 32'd2);
        check("wb_count", {16'd0, WB_COUNT}, 32'd1);
`endif
        do_req(1'b1, 1'b1, 8'h05, 8'h7F);   // both strobes: treated as write
        do_req(1'b1, 1'b0, 8'h05, 8'h00);

        // Reset in the middle of a fill.
        mem_lat = 6;
        @(posedge CLK);
        #1;
        READ    = 1'b1;
        ADDRESS = 8'h50;
        begin
            automatic int n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!MEM_READ && n < 20);
        end
        check("fill_started", {31'd0, MEM_READ}, 32'd1);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        READ  = 1'b0;
        @(negedge CLK);
        check("rst_abort_mem_read", {31'd0, MEM_READ}, 32'd0);
        check("rst_abort_busywait", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        mem_lat = 1;
        do_req(1'b1, 1'b0, 8'h50, 8'h00);   // misses again
        do_req(1'b1, 1'b0, 8'h05, 8'h00);   // dirty 0x7F was lost

        // Index wrap: 0x00 and 0x20 share line 0.
        mem_lat = 0;
        do_req(1'b0, 1'b1, 8'h00, 8'h99);
        do_req(1'b1, 1'b0, 8'h20, 8'h00);
        do_req(1'b1, 1'b0, 8'h00, 8'h00);

        for (int it = 0; it < 300; it++) begin
            automatic int unsigned op = $urandom_range(0, 3);
            automatic logic [7:0] a;
            a[7:5]  = 3'($urandom_range(0, 2));
            a[4:0]  = 5'($urandom);
            mem_lat = $urandom_range(0, 4);
            if ($urandom_range(0, 49) == 0) do_reset();
            do_req(op != 1, op == 1 || op == 2, a, 8'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
        end

        repeat (4) @(negedge CLK);
        check("req_queue_drained", req_q.size(), 32'd0);
        check("mem_queue_drained", mem_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
